// File: rtl/dsn_lif_core_if.sv
// Bundle of synaptic inputs, live control values and neuron outputs for one LIF neuron.
// The core drives the outputs through the slave modport; the upstream stage uses master.
interface dsn_lif_core_if #(
  parameter int IN_W  = 9,
  parameter int V_W   = 13,
  parameter int CNT_W = 8
);
  logic             io_in_valid;
  logic [IN_W-1:0]  io_vpre;
  logic [V_W-1:0]   io_vleak;
  logic [V_W-1:0]   io_vth;
  logic [CNT_W-1:0] io_refrac;
  logic [V_W-1:0]   io_vmem;
  logic             io_spike;
  logic             io_refrac_busy;
  logic [CNT_W-1:0] io_cyclecounter;
  logic             io_flag_active;
  logic             io_sat;

  modport master (
    output io_in_valid, io_vpre, io_vleak, io_vth, io_refrac,
    input  io_vmem, io_spike, io_refrac_busy, io_cyclecounter, io_flag_active, io_sat
  );

  modport slave (
    input  io_in_valid, io_vpre, io_vleak, io_vth, io_refrac,
    output io_vmem, io_spike, io_refrac_busy, io_cyclecounter, io_flag_active, io_sat
  );
endinterface

// File: rtl/dsn_lif_core.sv
// Leaky integrate-and-fire neuron: registered sign-magnitude input stage, saturating
// membrane update with leak, one-cycle spike and a programmable refractory period.
module dsn_lif_core #(
  parameter int IN_W  = 9,
  parameter int V_W   = 13,
  parameter int CNT_W = 8
) (
  input  logic          clock,
  input  logic          reset,
  dsn_lif_core_if.slave lif
);
  localparam int SW = V_W + 2;
  localparam logic [V_W-1:0]   V_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {ST_INTEGRATE, ST_REFRACT} state_t;

  state_t state_reg, state_next;

  logic              in_v_reg;
  logic              in_sign_reg;
  logic [IN_W-2:0]   in_mag_reg;
  logic              flag_active_reg;

  logic [V_W-1:0]    vmem_reg, vmem_next;
  logic              spike_reg, spike_next;
  logic [CNT_W-1:0]  cc_reg, cc_next;
  logic [CNT_W-1:0]  rcnt_reg, rcnt_next;
  logic              sat_reg, sat_next;

  logic signed [SW-1:0] mag_ext, syn_s, sum_s;
  logic [V_W-1:0]       clamped;
  logic                 ovf;
  logic                 fire;

  always_ff @(posedge clock) begin
    if (reset) begin
      in_v_reg        <= 1'b0;
      in_sign_reg     <= 1'b0;
      in_mag_reg      <= '0;
      flag_active_reg <= 1'b0;
    end else begin
      in_v_reg    <= lif.io_in_valid;
      in_sign_reg <= lif.io_vpre[IN_W-1];
      in_mag_reg  <= lif.io_vpre[IN_W-2:0];
      if (lif.io_in_valid)
        flag_active_reg <= (lif.io_vpre[IN_W-2:0] != '0);
    end
  end

  // Negative zero falls out naturally: -0 == 0 in two's complement.
  always_comb begin
    mag_ext = $signed({{(SW-IN_W+1){1'b0}}, in_mag_reg});
    syn_s   = '0;
    if (in_v_reg)
      syn_s = in_sign_reg ? -mag_ext : mag_ext;
    sum_s   = $signed({2'b00, vmem_reg}) + syn_s - $signed({2'b00, lif.io_vleak});
    clamped = sum_s[V_W-1:0];
    ovf     = 1'b0;
    if (sum_s[SW-1]) begin
      clamped = '0;
    end else if (sum_s > $signed({2'b00, V_MAX})) begin
      clamped = V_MAX;
      ovf     = 1'b1;
    end
    fire = (lif.io_vth != '0) && (clamped >= lif.io_vth);
  end

  always_comb begin
    state_next = state_reg;
    vmem_next  = vmem_reg;
    spike_next = 1'b0;
    cc_next    = (cc_reg == CNT_MAX) ? cc_reg : cc_reg + 1'b1;
    rcnt_next  = rcnt_reg;
    sat_next   = sat_reg;
    case (state_reg)
      ST_INTEGRATE: begin
        sat_next = sat_reg | ovf;
        if (fire) begin
          spike_next = 1'b1;
          vmem_next  = '0;
          cc_next    = '0;
          if (lif.io_refrac != '0) begin
            rcnt_next  = lif.io_refrac;
            state_next = ST_REFRACT;
          end
        end else begin
          vmem_next = clamped;
        end
      end
      ST_REFRACT: begin
        // Inputs and leak are ignored; the membrane stays parked at zero.
        vmem_next = '0;
        rcnt_next = rcnt_reg - 1'b1;
        if (rcnt_reg == CNT_W'(1))
          state_next = ST_INTEGRATE;
      end
      default: state_next = ST_INTEGRATE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_INTEGRATE;
      vmem_reg  <= '0;
      spike_reg <= 1'b0;
      cc_reg    <= '0;
      rcnt_reg  <= '0;
      sat_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      vmem_reg  <= vmem_next;
      spike_reg <= spike_next;
      cc_reg    <= cc_next;
      rcnt_reg  <= rcnt_next;
      sat_reg   <= sat_next;
    end
  end

  assign lif.io_vmem         = vmem_reg;
  assign lif.io_spike        = spike_reg;
  assign lif.io_refrac_busy  = (state_reg == ST_REFRACT);
  assign lif.io_cyclecounter = cc_reg;
  assign lif.io_flag_active  = flag_active_reg;
  assign lif.io_sat          = sat_reg;
endmodule

// File: tb/tb_dsn_lif_core.sv
// Scoreboard bench for dsn_lif_core: a cycle model queues expected outputs per edge,
// a monitor pops and compares them; directed checks cover the key scenarios.
module tb_dsn_lif_core;
  logic clock = 1'b0;
  logic reset = 1'b1;

  dsn_lif_core_if #(.IN_W(9), .V_W(13), .CNT_W(8)) lif ();

  dsn_lif_core #(.IN_W(9), .V_W(13), .CNT_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .lif   (lif)
  );

  always #5 clock = ~clock;

  typedef struct {
    int vmem;
    int spike;
    int busy;
    int cc;
    int flag;
    int sat;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc_idx  = 0;
  int n_spikes = 0;

  // Reference model state
  int m_vmem = 0, m_spike = 0, m_refr = 0, m_rc = 0, m_cc = 0, m_flag = 0, m_sat = 0;
  int m_v = 0, m_neg = 0, m_mag = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc_idx);
    end
  endtask

  task automatic model_step(input bit rst, input bit v, input logic [8:0] vp);
    int syn;
    int n;
    exp_t e;
    if (rst) begin
      m_vmem = 0; m_spike = 0; m_refr = 0; m_rc = 0; m_cc = 0; m_flag = 0; m_sat = 0;
      m_v = 0; m_neg = 0; m_mag = 0;
    end else begin
      syn = (m_v == 0) ? 0 : ((m_neg != 0) ? -m_mag : m_mag);
      m_spike = 0;
      if (m_refr != 0) begin
        m_vmem = 0;
        m_cc = (m_cc < 255) ? m_cc + 1 : 255;
        m_rc = m_rc - 1;
        if (m_rc == 0) m_refr = 0;
      end else begin
        n = m_vmem + syn - int'(lif.io_vleak);
        if (n < 0) n = 0;
        if (n > 8191) begin
          n = 8191;
          m_sat = 1;
        end
        if (lif.io_vth != 0 && n >= int'(lif.io_vth)) begin
          m_spike = 1;
          m_vmem = 0;
          m_cc = 0;
          if (lif.io_refrac != 0) begin
            m_refr = 1;
            m_rc = int'(lif.io_refrac);
          end
        end else begin
          m_vmem = n;
          m_cc = (m_cc < 255) ? m_cc + 1 : 255;
        end
      end
      if (v) m_flag = (vp[7:0] != 0) ? 1 : 0;
      m_v = v;
      m_neg = vp[8];
      m_mag = vp[7:0];
    end
    e.vmem = m_vmem; e.spike = m_spike; e.busy = m_refr;
    e.cc = m_cc; e.flag = m_flag; e.sat = m_sat;
    exp_q.push_back(e);
  endtask

  // Drive one edge worth of stimulus; returns at the following falling edge.
  task automatic cyc(input bit rst, input bit v, input logic [8:0] vp);
    reset = rst;
    lif.io_in_valid = v;
    lif.io_vpre = vp;
    model_step(rst, v, vp);
    @(negedge clock);
    cyc_idx++;
    if (lif.io_spike === 1'b1) n_spikes++;
  endtask

  always @(posedge clock) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val("sb_vmem",  32'(lif.io_vmem), e.vmem);
      check_val("sb_spike", 32'(lif.io_spike), e.spike);
      check_val("sb_busy",  32'(lif.io_refrac_busy), e.busy);
      check_val("sb_cc",    32'(lif.io_cyclecounter), e.cc);
      check_val("sb_flag",  32'(lif.io_flag_active), e.flag);
      check_val("sb_sat",   32'(lif.io_sat), e.sat);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_spk;
    int second_spk;
    int busy_cnt;
    int spk_before;
    int waited;
    lif.io_in_valid = 1'b0;
    lif.io_vpre = '0;
    lif.io_vleak = 13'd0;
    lif.io_vth = 13'd100;
    lif.io_refrac = 8'd0;

    // Reset state
    cyc(1, 0, 9'd0);
    cyc(1, 0, 9'd0);
    check_val("rst_vmem", 32'(lif.io_vmem), 0);
    check_val("rst_spike", 32'(lif.io_spike), 0);
    check_val("rst_busy", 32'(lif.io_refrac_busy), 0);
    check_val("rst_cc", 32'(lif.io_cyclecounter), 0);

    // Integrate +30 four times, threshold 100
    cyc(0, 1, 9'd30);
    cyc(0, 1, 9'd30);
    check_val("int_30", 32'(lif.io_vmem), 30);
    cyc(0, 1, 9'd30);
    check_val("int_60", 32'(lif.io_vmem), 60);
    cyc(0, 1, 9'd30);
    check_val("int_90", 32'(lif.io_vmem), 90);
    cyc(0, 0, 9'd0);
    check_val("fire_spike", 32'(lif.io_spike), 1);
    check_val("fire_vmem", 32'(lif.io_vmem), 0);
    check_val("fire_cc", 32'(lif.io_cyclecounter), 0);
    cyc(0, 0, 9'd0);
    check_val("fire_1cyc", 32'(lif.io_spike), 0);

    // Leak drains 12 down to 0 and clamps
    lif.io_vleak = 13'd5;
    cyc(0, 1, 9'd12);
    cyc(0, 0, 9'd0);
    check_val("leak_7", 32'(lif.io_vmem), 7);
    cyc(0, 0, 9'd0);
    check_val("leak_2", 32'(lif.io_vmem), 2);
    cyc(0, 0, 9'd0);
    check_val("leak_0", 32'(lif.io_vmem), 0);
    cyc(0, 0, 9'd0);
    check_val("leak_hold0", 32'(lif.io_vmem), 0);
    check_val("leak_nosat", 32'(lif.io_sat), 0);
    lif.io_vleak = 13'd0;

    // Refractory: vth 50, refrac 3, +60 held
    lif.io_vth = 13'd50;
    lif.io_refrac = 8'd3;
    first_spk = -1;
    second_spk = -1;
    busy_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      cyc(0, 1, 9'd60);
      if (lif.io_spike === 1'b1) begin
        if (first_spk < 0) first_spk = cyc_idx;
        else if (second_spk < 0) second_spk = cyc_idx;
      end
      if (lif.io_refrac_busy === 1'b1 && first_spk >= 0 && second_spk < 0) busy_cnt++;
    end
    check_val("refr_busy_len", 32'(busy_cnt), 3);
    check_val("refr_spacing", 32'(second_spk - first_spk), 4);

    // Drain back to idle integrate with vmem 0
    lif.io_vth = 13'd100;
    lif.io_vleak = 13'd20;
    for (int i = 0; i < 8; i++) cyc(0, 0, 9'd0);
    lif.io_vleak = 13'd0;
    check_val("drain_vmem", 32'(lif.io_vmem), 0);

    // Inhibitory input and negative zero
    cyc(0, 1, 9'd25);
    check_val("flag_on", 32'(lif.io_flag_active), 1);
    cyc(0, 0, 9'd0);
    check_val("pre_inh_25", 32'(lif.io_vmem), 25);
    cyc(0, 1, {1'b1, 8'd40});
    cyc(0, 0, 9'd0);
    check_val("inh_clamp0", 32'(lif.io_vmem), 0);
    cyc(0, 1, 9'd25);
    cyc(0, 1, {1'b1, 8'd0});
    check_val("negzero_flag", 32'(lif.io_flag_active), 0);
    check_val("pre_nz_25", 32'(lif.io_vmem), 25);
    cyc(0, 0, 9'd0);
    check_val("negzero_vmem", 32'(lif.io_vmem), 25);

    // vth 0: saturate membrane and cycle counter, never fire
    lif.io_vth = 13'd0;
    spk_before = n_spikes;
    for (int i = 0; i < 300; i++) cyc(0, 1, 9'd255);
    check_val("sat_vmem", 32'(lif.io_vmem), 8191);
    check_val("sat_flag", 32'(lif.io_sat), 1);
    check_val("sat_nospike", 32'(n_spikes - spk_before), 0);
    check_val("sat_cc", 32'(lif.io_cyclecounter), 255);
    cyc(0, 0, 9'd0);
    check_val("sat_sticky", 32'(lif.io_sat), 1);

    // Reset in the middle of a refractory period
    lif.io_vth = 13'd50;
    lif.io_refrac = 8'd10;
    waited = 0;
    while (lif.io_refrac_busy !== 1'b1 && waited < 8) begin
      cyc(0, 1, 9'd60);
      waited++;
    end
    check_val("refr_entered", 32'(lif.io_refrac_busy), 1);
    cyc(0, 1, 9'd60);
    cyc(1, 1, 9'd60);
    check_val("mrst_vmem", 32'(lif.io_vmem), 0);
    check_val("mrst_busy", 32'(lif.io_refrac_busy), 0);
    check_val("mrst_sat", 32'(lif.io_sat), 0);
    check_val("mrst_flag", 32'(lif.io_flag_active), 0);
    lif.io_vth = 13'd100;
    lif.io_refrac = 8'd0;
    cyc(0, 1, 9'd30);
    cyc(0, 0, 9'd0);
    check_val("post_rst_30", 32'(lif.io_vmem), 30);

    // Random tail exercised only through the scoreboard
    lif.io_refrac = 8'd2;
    for (int i = 0; i < 60; i++) begin
      lif.io_vleak = 13'($urandom_range(0, 8));
      cyc(0, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)));
    end
    cyc(0, 0, 9'd0);
    @(posedge clock);
    #2;
    check_val("sb_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
